// File: rtl/jk_updown_counter_pkg.sv
// Shared types for the JK up/down counter: excitation modes and the JK pair
// that moves one cell from its current bit to a required next bit.
package jk_updown_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_LOAD  = 2'b10
    } mode_e;

    typedef struct packed {
        logic j;
        logic k;
    } jk_t;

    // Set/reset encoding: J raises a 0 bit, K clears a 1 bit, else hold.
    function automatic jk_t jk_from(input logic cur, input logic nxt);
        jk_t r;
        r.j = nxt & ~cur;
        r.k = ~nxt & cur;
        return r;
    endfunction

endpackage

// File: rtl/jk_updown_counter_jk_cell.sv
// Single JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle.
// Asynchronous active-high clear forces the cell to 0.
module jk_cell (
    input  logic clk,
    input  logic clear,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // NOTE: q_d takes a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        q_d = q_q;
        unique case ({j, k})
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // NOTE: state registers update with <= so every cell samples the old count on the same edge.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK cells. Excitation is
// derived from the required next count so all bits move on the same edge.
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    mode_e            mode;
    logic [WIDTH-1:0] next;
    logic             boundary;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             wrap_q;
    logic             wrap_d;

    always_comb begin
        mode     = MODE_HOLD;
        next     = q;
        boundary = 1'b0;
        if (load) begin
            mode = MODE_LOAD;
            next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            mode = MODE_COUNT;
            if (up) begin
                // Anything at or above the top value (including out-of-range) restarts at 0.
                if (q >= MAX_VAL) begin
                    next     = '0;
                    boundary = 1'b1;
                end else begin
                    next = q + ONE;
                end
            end else if (q == '0) begin
                next     = MAX_VAL;
                boundary = 1'b1;
            end else begin
                next = q - ONE;
            end
        end
    end

    always_comb begin
        j_vec = '0;
        k_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            jk_t pair;
            pair = jk_from(q[i], next[i]);
            unique case (mode)
                MODE_HOLD: begin
                    j_vec[i] = 1'b0;
                    k_vec[i] = 1'b0;
                end
                MODE_COUNT: begin
                    // Ordinary steps use pure toggle excitation; wraps use set/reset.
                    if (boundary) begin
                        j_vec[i] = pair.j;
                        k_vec[i] = pair.k;
                    end else begin
                        j_vec[i] = q[i] ^ next[i];
                        k_vec[i] = q[i] ^ next[i];
                    end
                end
                default: begin
                    j_vec[i] = pair.j;
                    k_vec[i] = pair.k;
                end
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .clear (clear),
            .j     (j_vec[g]),
            .k     (k_vec[g]),
            .q     (q[g])
        );
    end

    assign tc     = en & ~load & ((up & (q == MAX_VAL)) | (~up & (q == '0)));
    assign wrap_d = tc;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares against a decade counter and a 3-bit binary one.
module tb_jk_updown_counter;

    typedef struct {
        string      name;
        int         dut;
        logic [3:0] q;
        logic       tc;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear, en, up, load;
    logic [3:0] load_val;
    logic [3:0] q_a;
    logic       tc_a, wrap_a;
    logic [2:0] q_b;
    logic       tc_b, wrap_b;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    jk_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q_a), .tc(tc_a), .wrap(wrap_a)
    );

    jk_updown_counter #(.WIDTH(3), .MODULUS(8)) u_bin (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load),
        .load_val(load_val[2:0]), .q(q_b), .tc(tc_b), .wrap(wrap_b)
    );

    task automatic check(input string nm, input logic [3:0] aq, input logic at, input logic aw,
                         input logic [3:0] eq, input logic et, input logic ew);
        n_tests++;
        if (aq !== eq || at !== et || aw !== ew) begin
            n_fail++;
            $display("FAIL %s: got q=%0d tc=%b wrap=%b, expected q=%0d tc=%b wrap=%b",
                     nm, aq, at, aw, eq, et, ew);
        end
    endtask

    // Drive inputs just after an edge; expectation is for the state seen before the next edge.
    task automatic cyc(input string nm, input logic c, input logic ld, input logic e,
                       input logic u, input logic [3:0] v,
                       input logic [3:0] eq, input logic et, input logic ew, input int d);
        exp_t x;
        @(posedge clk);
        #1;
        clear = c; load = ld; en = e; up = u; load_val = v;
        x.name = nm; x.dut = d; x.q = eq; x.tc = et; x.wrap = ew;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (x.dut == 0) check(x.name, q_a, tc_a, wrap_a, x.q, x.tc, x.wrap);
                else            check(x.name, {1'b0, q_b}, tc_b, wrap_b, x.q, x.tc, x.wrap);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [3:0] up_q[12]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                  4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
        logic [3:0] bin_q[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                                  4'd5, 4'd6, 4'd7, 4'd0, 4'd1};
        clear = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0; load_val = 4'd0;

        // Reset, clear-held edges, count to 5, async clear mid-cycle, release.
        cyc("reset",            1, 0, 0, 0, 0,  0, 0, 0, 0);
        cyc("clr_hold",         1, 0, 1, 1, 0,  0, 0, 0, 0);
        cyc("clr_edge_ignored", 0, 0, 1, 1, 0,  0, 0, 0, 0);
        cyc("first_edge",       0, 0, 1, 1, 0,  1, 0, 0, 0);
        cyc("up_2",             0, 0, 1, 1, 0,  2, 0, 0, 0);
        cyc("up_3",             0, 0, 1, 1, 0,  3, 0, 0, 0);
        cyc("up_4",             0, 0, 1, 1, 0,  4, 0, 0, 0);
        cyc("at_5",             0, 0, 0, 1, 0,  5, 0, 0, 0);
        cyc("async_clear",      1, 0, 1, 1, 0,  0, 0, 0, 0);
        cyc("released",         0, 0, 1, 1, 0,  0, 0, 0, 0);
        cyc("after_release",    0, 0, 1, 1, 0,  1, 0, 0, 0);

        // Up wrap over 12 edges from a loaded 0.
        cyc("pre_load0",        0, 1, 1, 1, 0,  2, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc($sformatf("up_run_%0d", i), 0, 0, 1, 1, 0,
                up_q[i], (i == 9), (i == 10), 0);
        end

        // Down wrap from a loaded 0.
        cyc("up_run_end",       0, 1, 1, 0, 0,  2, 0, 0, 0);
        cyc("dn_q0",            0, 0, 1, 0, 0,  0, 1, 0, 0);
        cyc("dn_q9",            0, 0, 1, 0, 0,  9, 0, 1, 0);
        cyc("dn_q8",            0, 0, 1, 0, 0,  8, 0, 0, 0);

        // Clamp of 13, then load 3 while sitting at 9 counting up.
        cyc("dn_q7",            0, 1, 1, 1, 13, 7, 0, 0, 0);
        cyc("clamp",            0, 1, 1, 1, 3,  9, 0, 0, 0);
        cyc("load3_no_wrap",    0, 1, 0, 1, 6,  3, 0, 0, 0);

        // Hold at 6 for three edges, then tc at 0 and a direction flip.
        cyc("hold_1",           0, 0, 0, 1, 0,  6, 0, 0, 0);
        cyc("hold_2",           0, 0, 0, 1, 0,  6, 0, 0, 0);
        cyc("hold_3",           0, 0, 0, 1, 0,  6, 0, 0, 0);
        cyc("hold_done",        0, 1, 0, 0, 0,  6, 0, 0, 0);
        cyc("tc_down_at0",      0, 0, 1, 0, 0,  0, 1, 0, 0);
        @(negedge clk);
        #1;
        up = 1'b1;
        #1;
        check("tc_dir_flip", q_a, tc_a, wrap_a, 4'd0, 1'b0, 1'b0);
        cyc("after_flip",       0, 0, 0, 1, 0,  1, 0, 0, 0);

        // Binary counter instance: 9 edges from 0 after a shared clear.
        cyc("reclear",          1, 0, 0, 1, 0,  0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("bin_run_%0d", i), 0, 0, (i < 9), 1, 0,
                bin_q[i], (i == 7), (i == 8), 1);
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_updown_counter.md
Name: jk_updown_counter

Overview:
- Synchronous modulo-N up/down counter built from JK flip-flop cells, one cell per bit.
- Combinational excitation logic produces J/K for every bit from the current count, direction and enable, so all bits change on the same clock edge.
- Feeds downstream display/decoder stages with a count plus terminal-count and wrap indications for cascading.

Parameters:
- WIDTH, 4, number of count bits / JK cells.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous reset, active-high. Forces all state to reset values immediately.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  current count (JK cell outputs).
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse after a wrap-around.

Behaviour:
- Reset: clear=1 asynchronously drives q=0 and wrap=0, regardless of clk. tc follows from q.
  - While clear=1, rising clk edges have no effect.
  - The first edge after clear deasserts is evaluated normally.
- Priority at each rising clk edge: clear > load > en > hold.
- Load (load=1):
  - q <= load_val if load_val <= MODULUS-1; otherwise q <= MODULUS-1 (saturating clamp).
  - en and up are ignored.
  - wrap <= 0.
- Count (load=0, en=1):
  - up=1: q <= q+1, except q==MODULUS-1 gives q <= 0.
  - up=0: q <= q-1, except q==0 gives q <= MODULUS-1.
  - The new value is visible one cycle after the edge (latency 1).
- Hold (load=0, en=0): q unchanged, wrap <= 0.
- Excitation rules:
  - Each bit i receives J_i = K_i = 1 when the bit must toggle; otherwise J_i = K_i = 0. Set/reset encodings are not used.
  - At the wrap boundaries and during load, the per-bit J/K are derived as J_i = next_i & ~q_i and K_i = ~next_i & q_i.
  - next_i is the required next bit value.
- tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)). It is purely combinational, so a direction change in the same cycle updates tc immediately.
- wrap <= tc at each edge, i.e. a 1-cycle pulse in the cycle after q wraps.
- Out-of-range q (e.g. from future misuse, or WIDTH power-of-2 > MODULUS): up-counting from a value > MODULUS-1 goes to 0 on the next enabled edge. Down-counting from such a value decrements normally.
- MODULUS == 2**WIDTH: the counter is a plain binary counter. Wrap follows the same rules with no special case.
- Simultaneous load and wrap condition: load wins, wrap <= 0.

Decomposition:
- Shared package/header holds:
  - Mode encodings for the excitation selector: HOLD=2'b00, COUNT=2'b01, LOAD=2'b10.
  - A function computing the JK pair from (current bit, next bit).
- Sub-module jk_cell:
  - Single JK flip-flop with clk, async active-high clear, J, K, and output q.
  - Semantics: JK=00 hold, 01 reset, 10 set, 11 toggle.
  - Instantiated WIDTH times via generate.
- Top level contains the next-state/excitation logic, tc, and the wrap register.

Test Plan:
1. Reset mid-operation: count up to q=5, assert clear asynchronously between edges → q=0 and wrap=0 immediately. Next edge after release with en=1, up=1 → q=1.
2. Up wrap, MODULUS=10: en=1, up=1 from 0 for 12 edges → q goes 0..9,0,1,2. tc=1 only while q=9. wrap=1 for exactly the one cycle after q goes 9→0.
3. Down wrap: load 0, then en=1, up=0 → q sequence 9,8,7. tc=1 while q=0 with up=0. wrap pulses once after 0→9.
4. Load priority and clamp: load=1, load_val=4'd13, en=1 → q=9, wrap=0. load=1, load_val=4'd3 at q=9 with up=1 → q=3, no wrap pulse.
5. Hold and direction flip: en=0 for 3 edges at q=6 → q stays 6, tc=0. At q=0, toggle up 0→1 combinationally → tc drops from 1 to 0 in the same cycle.
6. Binary mode WIDTH=3, MODULUS=8: en=1, up=1 for 9 edges → q=0..7,0,1. Exactly one wrap pulse.
